// File: rtl/alu_shift_right_seq.sv
// Sequential right-shift unit: shifts an operand right by Shamt positions,
// one bit per clock, with logical (zero) or arithmetic (sign) fill.
// Valid/ready handshakes on both the request and the result side.
module alu_shift_right_seq #(
  parameter int WIDTH   = 128,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Result,
  output logic               Cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               fill_q, fill_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      cout_q   <= 1'b0;
      count_q  <= '0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      count_q  <= count_d;
      fill_q   <= fill_d;
    end
  end

  // Next-state and datapath update: capture in IDLE, one shift step per
  // cycle in SHIFT, hold in DONE until the consumer takes the result.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cout_d   = cout_q;
    count_d  = count_q;
    fill_d   = fill_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          result_d = A;
          cout_d   = 1'b0;
          count_d  = Shamt;
          // Fill comes from the captured MSB so later input changes
          // cannot affect an operation in flight.
          fill_d   = Arith & A[WIDTH-1];
          state_d  = (Shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        result_d = {fill_q, result_q[WIDTH-1:1]};
        cout_d   = result_q[0];
        count_d  = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign Cout      = cout_q;

endmodule

// File: tb/tb_alu_shift_right_seq.sv
// Directed self-checking bench for alu_shift_right_seq at WIDTH=8 and WIDTH=128.
module tb_alu_shift_right_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8, ar8, co8;
  logic [7:0] a8, r8;
  logic [2:0] sh8;

  logic         iv1, ir1, ov1, or1, ar1, co1;
  logic [127:0] a1, r1;
  logic [6:0]   sh1;

  int n_checks = 0;
  int n_fail   = 0;

  alu_shift_right_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .A(a8), .Shamt(sh8), .Arith(ar8),
    .out_valid(ov8), .out_ready(or8), .Result(r8), .Cout(co8)
  );

  alu_shift_right_seq #(.WIDTH(128)) u128 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1), .A(a1), .Shamt(sh1), .Arith(ar1),
    .out_valid(ov1), .out_ready(or1), .Result(r1), .Cout(co1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (the accepting edge).
  task automatic issue8(input logic [7:0] a, input int sh, input logic ar);
    iv8 = 1'b1; a8 = a; sh8 = sh[2:0]; ar8 = ar;
    tick();
    iv8 = 1'b0;
  endtask

  task automatic issue128(input logic [127:0] a, input int sh, input logic ar);
    iv1 = 1'b1; a1 = a; sh1 = sh[6:0]; ar1 = ar;
    tick();
    iv1 = 1'b0;
  endtask

  // Edges counted include the accepting edge; -1 means the bound expired.
  task automatic wait_done8(output int edges);
    edges = 1;
    while (!ov8 && edges < 300) begin
      tick();
      edges++;
    end
    if (!ov8) edges = -1;
  endtask

  task automatic wait_done128(output int edges);
    edges = 1;
    while (!ov1 && edges < 300) begin
      tick();
      edges++;
    end
    if (!ov1) edges = -1;
  endtask

  task automatic release8();
    or8 = 1'b1; tick(); or8 = 1'b0;
  endtask

  task automatic release128();
    or1 = 1'b1; tick(); or1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8 got %b want 1", ir8); end
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8 got %b want 0", ov8); end
    n_checks++; if (r8 !== 8'h00) begin n_fail++; $display("FAIL reset_result8 got %h want 00", r8); end
    n_checks++; if (co8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout8 got %b want 0", co8); end
    n_checks++; if (ir1 !== 1'b1 || ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_hs128 got ir=%b ov=%b want 1 0", ir1, ov1); end
    n_checks++; if (r1 !== 128'h0 || co1 !== 1'b0) begin n_fail++; $display("FAIL reset_data128 got %h/%b want 0/0", r1, co1); end
  endtask

  task automatic test_logical();
    int e;
    issue8(8'hB4, 3, 1'b0);
    wait_done8(e);
    n_checks++; if (e !== 4) begin n_fail++; $display("FAIL logical_latency got %0d want 4", e); end
    n_checks++; if (r8 !== 8'h16) begin n_fail++; $display("FAIL logical_result got %h want 16", r8); end
    n_checks++; if (co8 !== 1'b1) begin n_fail++; $display("FAIL logical_cout got %b want 1", co8); end
    n_checks++; if (ir8 !== 1'b0) begin n_fail++; $display("FAIL logical_in_ready_done got %b want 0", ir8); end
    release8();
    tick();
    n_checks++; if (r8 !== 8'h16 || ov8 !== 1'b0 || ir8 !== 1'b1) begin
      n_fail++; $display("FAIL logical_idle_hold got r=%h ov=%b ir=%b want 16 0 1", r8, ov8, ir8);
    end
  endtask

  task automatic test_arith();
    int e;
    issue8(8'hB4, 3, 1'b1);
    // Inputs changing mid-operation must not disturb the captured request.
    a8 = 8'h00; ar8 = 1'b0; sh8 = 3'd1; iv8 = 1'b1;
    wait_done8(e);
    iv8 = 1'b0;
    n_checks++; if (e !== 4) begin n_fail++; $display("FAIL arith_latency got %0d want 4", e); end
    n_checks++; if (r8 !== 8'hF6) begin n_fail++; $display("FAIL arith_result got %h want F6", r8); end
    n_checks++; if (co8 !== 1'b1) begin n_fail++; $display("FAIL arith_cout got %b want 1", co8); end
    release8();
  endtask

  task automatic test_max_shift8();
    int e;
    issue8(8'h80, 7, 1'b1);
    wait_done8(e);
    n_checks++; if (e !== 8) begin n_fail++; $display("FAIL max8_arith_latency got %0d want 8", e); end
    n_checks++; if (r8 !== 8'hFF || co8 !== 1'b0) begin n_fail++; $display("FAIL max8_arith got %h/%b want FF/0", r8, co8); end
    release8();
    issue8(8'h80, 7, 1'b0);
    wait_done8(e);
    n_checks++; if (r8 !== 8'h01 || co8 !== 1'b0) begin n_fail++; $display("FAIL max8_logical got %h/%b want 01/0", r8, co8); end
    release8();
  endtask

  task automatic test_shamt_zero();
    int e;
    issue128(128'h1234, 0, 1'b0);
    wait_done128(e);
    n_checks++; if (e !== 1) begin n_fail++; $display("FAIL shamt0_latency got %0d want 1", e); end
    n_checks++; if (r1 !== 128'h1234 || co1 !== 1'b0) begin n_fail++; $display("FAIL shamt0_data got %h/%b want 1234/0", r1, co1); end
    release128();
  endtask

  task automatic test_max_shift128();
    int e;
    logic [127:0] a;
    a = 128'h1 << 127;
    issue128(a, 127, 1'b0);
    wait_done128(e);
    n_checks++; if (e !== 128) begin n_fail++; $display("FAIL max128_latency got %0d want 128", e); end
    n_checks++; if (r1 !== 128'h1 || co1 !== 1'b0) begin n_fail++; $display("FAIL max128_logical got %h/%b want 1/0", r1, co1); end
    release128();
    issue128(a, 127, 1'b1);
    wait_done128(e);
    n_checks++; if (r1 !== {128{1'b1}} || co1 !== 1'b0) begin n_fail++; $display("FAIL max128_arith got %h/%b want all-ones/0", r1, co1); end
    release128();
  endtask

  task automatic test_backpressure();
    int e;
    issue8(8'hB4, 3, 1'b0);
    wait_done8(e);
    iv8 = 1'b1; a8 = 8'h5A; sh8 = 3'd1; ar8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (ov8 !== 1'b1 || ir8 !== 1'b0 || r8 !== 8'h16 || co8 !== 1'b1) begin
        n_fail++; $display("FAIL backpressure_hold[%0d] got ov=%b ir=%b r=%h c=%b want 1 0 16 1", i, ov8, ir8, r8, co8);
      end
    end
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    n_checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || r8 !== 8'h16) begin
      n_fail++; $display("FAIL backpressure_release got ir=%b ov=%b r=%h want 1 0 16", ir8, ov8, r8);
    end
    iv8 = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    int seen;
    issue8(8'hB4, 5, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin n_fail++; $display("FAIL midreset_hs got ir=%b ov=%b want 1 0", ir8, ov8); end
    n_checks++; if (r8 !== 8'h00 || co8 !== 1'b0) begin n_fail++; $display("FAIL midreset_data got %h/%b want 00/0", r8, co8); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ov8 === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_valid got %0d pulses want 0", seen); end
  endtask

  initial begin
    rst = 1'b0;
    iv8 = 1'b0; a8 = '0; sh8 = '0; ar8 = 1'b0; or8 = 1'b0;
    iv1 = 1'b0; a1 = '0; sh1 = '0; ar1 = 1'b0; or1 = 1'b0;
    test_reset();
    test_logical();
    test_arith();
    test_max_shift8();
    test_shamt_zero();
    test_max_shift128();
    test_backpressure();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_shift_right_seq.md
Name: alu_shift_right_seq

Overview:
- Sequential right-shift unit for the 128-bit ALU datapath; the opposite direction of the per-bit left shift chain in the logic slice (left shift passes Cin into the result and A out as Cout).
- Shifts an operand right by a programmable amount, one bit position per clock.
- Supports logical (zero-fill) and arithmetic (sign-fill) modes.
- Returns the shifted word and the last bit shifted out, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 128, operand and result width in bits (≥2).
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- A  input  WIDTH  operand.
- Shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- Arith  input  1  1 = fill with A[WIDTH-1] (sign); 0 = fill with 0.
- out_valid  output  1  Result/Cout valid.
- out_ready  input  1  consumer accepts result.
- Result  output  WIDTH  shifted operand.
- Cout  output  1  last bit shifted out of bit 0; 0 when Shamt = 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (rst high at an edge):
  - State = IDLE.
  - Result = 0, Cout = 0, out_valid = 0, in_ready = 1.
  - Count and fill registers = 0.
- States: IDLE, SHIFT, DONE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE. Both are decoded from state only, with no combinational path from inputs.
- IDLE: on an edge with in_valid = 1, capture the request:
  - Result <= A, Cout <= 0, count <= Shamt.
  - fill <= Arith & A[WIDTH-1].
  - If Shamt = 0, go to DONE; otherwise go to SHIFT.
  - If in_valid = 0, stay in IDLE; Result and Cout hold their last values.
- SHIFT: each edge performs one shift step:
  - Result <= {fill, Result[WIDTH-1:1]}, Cout <= Result[0], count <= count-1.
  - When count = 1 at the edge, the final step occurs and the state goes to DONE.
- DONE: Result and Cout are held stable.
  - On an edge with out_ready = 1, go to IDLE.
  - Otherwise hold indefinitely (backpressure).
- Latency: out_valid rises exactly Shamt+1 edges after the accepting edge. Throughput is one request per Shamt+2 cycles minimum.
- Back-to-back operation: a request cannot be accepted on the same edge that DONE→IDLE occurs, because in_ready is 0 in DONE. The next accept is at the earliest on the following edge.
- While in SHIFT or DONE, the A, Shamt, Arith and in_valid inputs are ignored. Captured values are unaffected by input changes.
- Fill source: fill is taken from the captured A MSB, not the live input.
- Shamt range: Shamt = WIDTH-1 is the maximum. The result equals the fill bit replicated, except bit 0 = A[WIDTH-1].
- Reset mid-operation (in SHIFT or DONE): the operation is aborted and no out_valid pulse is produced. The next cycle shows reset values.
- No X propagation: every register has a defined reset value.

Test Plan:
- WIDTH=8, A=8'hB4, Shamt=3, Arith=0 → out_valid 4 edges after accept; Result=8'h16, Cout=1.
- WIDTH=8, A=8'hB4, Shamt=3, Arith=1 → Result=8'hF6, Cout=1.
- WIDTH=8, A=8'h80, Shamt=7:
  - Arith=1 → Result=8'hFF, Cout=0.
  - Arith=0 → Result=8'h01, Cout=0.
- Shamt=0 (WIDTH=128, A=128'h1234) → out_valid after 1 edge, Result=A, Cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new A. Required:
  - out_valid stays 1, Result and Cout are unchanged, in_ready = 0.
  - The new request is not captured.
  - After out_ready=1, in_ready returns to 1 one edge later.
- WIDTH=128, A=128'h1<<127, Shamt=127, Arith=0 → Result=128'h1, Cout=0.
- Reset mid-op: assert rst 2 edges into Shamt=5 → next cycle state IDLE, in_ready=1, Result=0, Cout=0; out_valid never asserts.
